// File: rtl/data_bus_ctrl.sv
// Data-side bus controller: decodes processor data accesses into RAM and board I/O
// and stalls the processor for the synchronous RAM read latency.
module data_bus_ctrl #(
  parameter int RAM_LATENCY = 1,
  parameter int RAM_AW      = 12
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [15:0]       ProcAddr,
  input  logic [15:0]       ProcWrData,
  input  logic              ProcWrite,
  input  logic              ProcRead,
  output logic [15:0]       ProcRdData,
  output logic              ProcWaitreq,
  output logic [RAM_AW-1:0] MemAddr,
  output logic [15:0]       MemWrData,
  output logic              MemWrite,
  input  logic [15:0]       MemRdData,
  input  logic [9:0]        SW,
  input  logic [3:0]        KEY,
  output logic [9:0]        LEDR,
  output logic [41:0]       HexOut,
  output logic              BusErr
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state, state_nx;
  logic [1:0]  cnt, cnt_nx;
  logic [3:0]  key_s1, key_s2;
  logic        ram_hit, led_hit, hex_hit, sw_hit, key_hit, mapped;
  logic        rd_req, wr_go, err, wait_c;
  logic [2:0]  hex_sel;
  logic [6:0]  hex_rd;
  logic [15:0] io_rd, rd_c;

  assign ram_hit = {1'b0, ProcAddr} < (17'd1 << RAM_AW);
  assign led_hit = ProcAddr == 16'h1000;
  assign hex_hit = (ProcAddr[15:3] == 13'h0400) && (ProcAddr[2:0] < 3'd6);
  assign sw_hit  = ProcAddr == 16'h3000;
  assign key_hit = ProcAddr == 16'h4000;
  assign mapped  = ram_hit | led_hit | hex_hit | sw_hit | key_hit;
  assign hex_sel = ProcAddr[2:0];

  // A simultaneous write wins; the read half is dropped and flagged.
  assign rd_req = ProcRead & ~ProcWrite;
  assign wr_go  = ProcWrite & (state == S_IDLE);
  assign err    = ((ProcRead | ProcWrite) & ~mapped) | (ProcRead & ProcWrite);

  assign MemAddr   = ProcAddr[RAM_AW-1:0];
  assign MemWrData = ProcWrData;
  assign MemWrite  = ProcWrite & ram_hit & (state == S_IDLE) & Reset;

  always_comb begin
    hex_rd = '0;
    for (int n = 0; n < 6; n++)
      if (hex_sel == 3'(n)) hex_rd = HexOut[7*n +: 7];
  end

  always_comb begin
    io_rd = '0;
    if (led_hit)      io_rd = {6'b0, LEDR};
    else if (hex_hit) io_rd = {9'b0, hex_rd};
    else if (sw_hit)  io_rd = {6'b0, SW};
    else if (key_hit) io_rd = {12'b0, key_s2};
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    wait_c   = 1'b0;
    rd_c     = '0;
    case (state)
      S_IDLE: begin
        if (rd_req && ram_hit) begin
          wait_c   = 1'b1;
          cnt_nx   = 2'(RAM_LATENCY - 1);
          state_nx = (RAM_LATENCY == 1) ? S_DONE : S_WAIT;
        end else if (rd_req) begin
          rd_c = io_rd;
        end
      end
      S_WAIT: begin
        wait_c = 1'b1;
        cnt_nx = cnt - 2'd1;
        if (cnt == 2'd1) state_nx = S_DONE;
      end
      S_DONE: begin
        // Data is dropped if the processor abandoned the read.
        if (ProcRead) rd_c = MemRdData;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign ProcWaitreq = wait_c & Reset;
  assign ProcRdData  = rd_c;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      LEDR   <= '0;
      HexOut <= '1;
      BusErr <= 1'b0;
      key_s1 <= 4'hF;
      key_s2 <= 4'hF;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      key_s1 <= KEY;
      key_s2 <= key_s1;
      if (wr_go && led_hit) LEDR <= ProcWrData[9:0];
      for (int n = 0; n < 6; n++)
        if (wr_go && hex_hit && hex_sel == 3'(n)) HexOut[7*n +: 7] <= ProcWrData[6:0];
      if (err) BusErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Bench for data_bus_ctrl: two instances (RAM_LATENCY 1 and 3) share processor-side
// stimulus, each backed by a small RAM model with the matching read latency.
module tb_data_bus_ctrl;

  logic        Clock, Reset;
  logic [15:0] ProcAddr, ProcWrData;
  logic        ProcWrite, ProcRead;
  logic [9:0]  SW;
  logic [3:0]  KEY;

  logic [15:0] rd1, rd3, mrd1, mrd3;
  logic        w1, w3, mw1, mw3, be1, be3;
  logic [11:0] ma1, ma3;
  logic [15:0] mwd1, mwd3;
  logic [9:0]  led1, led3;
  logic [41:0] hex1, hex3;

  data_bus_ctrl #(.RAM_LATENCY(1), .RAM_AW(12)) dut1 (
    .Clock(Clock), .Reset(Reset), .ProcAddr(ProcAddr), .ProcWrData(ProcWrData),
    .ProcWrite(ProcWrite), .ProcRead(ProcRead), .ProcRdData(rd1), .ProcWaitreq(w1),
    .MemAddr(ma1), .MemWrData(mwd1), .MemWrite(mw1), .MemRdData(mrd1),
    .SW(SW), .KEY(KEY), .LEDR(led1), .HexOut(hex1), .BusErr(be1));

  data_bus_ctrl #(.RAM_LATENCY(3), .RAM_AW(12)) dut3 (
    .Clock(Clock), .Reset(Reset), .ProcAddr(ProcAddr), .ProcWrData(ProcWrData),
    .ProcWrite(ProcWrite), .ProcRead(ProcRead), .ProcRdData(rd3), .ProcWaitreq(w3),
    .MemAddr(ma3), .MemWrData(mwd3), .MemWrite(mw3), .MemRdData(mrd3),
    .SW(SW), .KEY(KEY), .LEDR(led3), .HexOut(hex3), .BusErr(be3));

  logic [15:0] mem1 [0:4095];
  logic [15:0] mem3 [0:4095];
  logic [15:0] p3 [0:2];

  always @(posedge Clock) begin
    if (mw1) mem1[ma1] <= mwd1;
    mrd1 <= mem1[ma1];
    if (mw3) mem3[ma3] <= mwd3;
    p3[0] <= mem3[ma3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mrd3 = p3[2];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic        exp_mw;
    string       name;
  } vec_t;

  vec_t vecs [10];

  // RAM read of 0x0010 watched on one instance; counts stall cycles and captures data.
  task automatic rd_ram(input bit sel3, input int lat, input string name);
    int n;
    bit got;
    logic [15:0] d;
    n = 0; got = 0; d = '0;
    @(negedge Clock);
    ProcRead = 1'b1; ProcWrite = 1'b0; ProcAddr = 16'h0010;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (!(sel3 ? w3 : w1)) begin
        d = sel3 ? rd3 : rd1;
        got = 1;
        break;
      end
      n++;
      @(negedge Clock);
    end
    @(posedge Clock);
    @(negedge Clock);
    ProcRead = 1'b0;
    chk({name, "_completed"}, 64'(got), 64'd1);
    chk({name, "_wait_cycles"}, 64'(n), 64'(lat));
    chk({name, "_data"}, d, 16'hBEEF);
    repeat (4) @(negedge Clock);
  endtask

  logic [41:0] hex_exp;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b1, "ram_wr"};
    vecs[1] = '{1'b1, 1'b0, 16'h1000, 16'h03FF, 16'h0000, 1'b0, "led_wr"};
    vecs[2] = '{1'b1, 1'b0, 16'h2003, 16'h0040, 16'h0000, 1'b0, "hex3_wr"};
    vecs[3] = '{1'b0, 1'b1, 16'h1000, 16'h0000, 16'h03FF, 1'b0, "led_rd"};
    vecs[4] = '{1'b0, 1'b1, 16'h2003, 16'h0000, 16'h0040, 1'b0, "hex3_rd"};
    vecs[5] = '{1'b0, 1'b1, 16'h2000, 16'h0000, 16'h007F, 1'b0, "hex0_rd"};
    vecs[6] = '{1'b0, 1'b1, 16'h2005, 16'h0000, 16'h007F, 1'b0, "hex5_rd"};
    vecs[7] = '{1'b1, 1'b0, 16'h3000, 16'h1234, 16'h0000, 1'b0, "sw_wr_ignored"};
    vecs[8] = '{1'b0, 1'b1, 16'h3000, 16'h0000, 16'h02A5, 1'b0, "sw_rd"};
    vecs[9] = '{1'b0, 1'b1, 16'h4000, 16'h0000, 16'h000E, 1'b0, "key_rd"};

    Reset = 1'b0; ProcAddr = '0; ProcWrData = '0; ProcWrite = 0; ProcRead = 0;
    SW = '0; KEY = 4'hF;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    chk("rst_wait", w1, 1'b0);
    chk("rst_led", led1, 10'h0);
    chk("rst_hex", hex1, 42'h3FF_FFFF_FFFF);
    chk("rst_buserr", be1, 1'b0);
    chk("idle_rd", rd1, 16'h0);

    SW = 10'h2A5; KEY = 4'b1110;
    repeat (3) @(negedge Clock);

    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      ProcWrite = vecs[i].wr; ProcRead = vecs[i].rd;
      ProcAddr = vecs[i].addr; ProcWrData = vecs[i].wdata;
      #1;
      chk({vecs[i].name, "_rd"}, rd1, vecs[i].exp_rd);
      chk({vecs[i].name, "_wait"}, w1, 1'b0);
      chk({vecs[i].name, "_memwr"}, mw1, vecs[i].exp_mw);
    end
    @(negedge Clock);
    ProcWrite = 0; ProcRead = 0;
    #1;
    hex_exp = '1;
    hex_exp[27:21] = 7'h40;
    chk("led_val", led1, 10'h3FF);
    chk("hex_val", hex1, hex_exp);
    chk("no_buserr", be1, 1'b0);

    rd_ram(1'b0, 1, "ram_lat1");
    rd_ram(1'b1, 3, "ram_lat3");

    // Abandon a read during WAIT: FSM must drain back to IDLE.
    @(negedge Clock);
    ProcRead = 1'b1; ProcAddr = 16'h0010;
    @(negedge Clock);
    ProcRead = 1'b0;
    repeat (5) @(negedge Clock);
    #1;
    chk("abandon_wait", w3, 1'b0);
    chk("abandon_rd", rd3, 16'h0);
    rd_ram(1'b1, 3, "after_abandon");

    // Unmapped read.
    @(negedge Clock);
    ProcRead = 1'b1; ProcAddr = 16'h5000;
    #1;
    chk("unmapped_rd", rd1, 16'h0);
    chk("unmapped_wait", w1, 1'b0);
    @(negedge Clock);
    ProcRead = 1'b0;
    #1;
    chk("unmapped_err", be1, 1'b1);
    repeat (3) @(negedge Clock);
    #1;
    chk("err_sticky1", be1, 1'b1);
    chk("err_sticky3", be3, 1'b1);

    // Reset in the middle of a latency-3 read.
    @(negedge Clock);
    ProcRead = 1'b1; ProcAddr = 16'h0010;
    #1;
    chk("midrd_wait", w3, 1'b1);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk("rst_forces_wait0", w3, 1'b0);
    @(negedge Clock);
    Reset = 1'b1; ProcRead = 1'b0;
    #1;
    chk("postrst_wait", w3, 1'b0);
    chk("postrst_led", led3, 10'h0);
    chk("postrst_hex", hex3, 42'h3FF_FFFF_FFFF);
    chk("postrst_err", be3, 1'b0);
    rd_ram(1'b1, 3, "postrst_read");

    // Read and write together: write lands, read ignored, error flagged.
    @(negedge Clock);
    ProcRead = 1'b1; ProcWrite = 1'b1; ProcAddr = 16'h1000; ProcWrData = 16'h0155;
    #1;
    chk("rw_rd", rd1, 16'h0);
    chk("rw_wait", w1, 1'b0);
    @(negedge Clock);
    ProcRead = 1'b0; ProcWrite = 1'b0;
    #1;
    chk("rw_led", led1, 10'h155);
    chk("rw_err", be1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
